// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame shifted on device clock, ACK check, per-phase timeouts.
// Optional `PS2_TX_GLITCH_FILTER_EN adds a 4-sample stability filter on the synchronised PS/2 clock.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC  = 6000,
  parameter int unsigned START_TO_CYC = 750000,
  parameter int unsigned PKT_TO_CYC   = 100000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o,
  output logic [1:0] tx_err_code_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o
);

  localparam int unsigned MAX_A   = (INHIBIT_CYC > START_TO_CYC) ? INHIBIT_CYC : START_TO_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > PKT_TO_CYC) ? MAX_A : PKT_TO_CYC;
  localparam int          TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TO_CYC - 1);
  localparam logic [TW-1:0] PKT_LAST   = TW'(PKT_TO_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_WAIT_CLK,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic          dat_bit_q, dat_bit_d;
  logic [1:0]    code_q, code_d;

  logic clk_s1_q, clk_s2_q;
  logic dat_s1_q, dat_s2_q;
  logic clk_prev_q;
  logic clk_lvl;
  logic fe;

  // Idle bus level is high, so synchronisers reset to 1 to avoid a false edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat_i;
      dat_s2_q <= dat_s1_q;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic       filt_q, filt_d;
  logic [1:0] fcnt_q, fcnt_d;

  // Level follows the input only after four consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == 2'd3) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign clk_lvl = filt_q;
`else
  assign clk_lvl = clk_s2_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_prev_q <= 1'b1;
    end else begin
      clk_prev_q <= clk_lvl;
    end
  end

  assign fe = clk_prev_q & ~clk_lvl;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      dat_bit_q <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      dat_bit_q <= dat_bit_d;
      code_q    <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    dat_bit_d = dat_bit_q;
    code_d    = code_q;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (tx_valid_i) begin
          shift_d = {1'b1, ~^tx_data_i, tx_data_i};
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == INH_LAST) begin
          timer_d = '0;
          state_d = S_REQ;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_REQ: begin
        timer_d = '0;
        state_d = S_WAIT_CLK;
      end
      S_WAIT_CLK: begin
        if (fe) begin
          dat_bit_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bitcnt_d  = 4'd1;
          timer_d   = '0;
          state_d   = S_SHIFT;
        end else if (timer_q == START_LAST) begin
          timer_d = '0;
          code_d  = 2'd1;
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      // Packet timer keeps running across SHIFT, ACK and WAIT_IDLE
      S_SHIFT: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == PKT_LAST) begin
          timer_d = '0;
          code_d  = 2'd2;
          state_d = S_ERR;
        end else if (fe) begin
          dat_bit_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bitcnt_d  = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == PKT_LAST) begin
          timer_d = '0;
          code_d  = 2'd2;
          state_d = S_ERR;
        end else if (fe) begin
          if (dat_s2_q) begin
            timer_d = '0;
            code_d  = 2'd3;
            state_d = S_ERR;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == PKT_LAST) begin
          timer_d = '0;
          code_d  = 2'd2;
          state_d = S_ERR;
        end else if (clk_lvl && dat_s2_q) begin
          timer_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_ready_o    = 1'b0;
    tx_busy_o     = 1'b1;
    tx_done_o     = 1'b0;
    tx_err_o      = 1'b0;
    tx_err_code_o = code_q;
    ps2_clk_oe_o  = 1'b0;
    ps2_dat_oe_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_ready_o = 1'b1;
        tx_busy_o  = 1'b0;
      end
      S_INHIBIT: begin
        ps2_clk_oe_o = 1'b1;
      end
      S_REQ: begin
        ps2_clk_oe_o = 1'b1;
        ps2_dat_oe_o = 1'b1;
      end
      S_WAIT_CLK: begin
        ps2_dat_oe_o = 1'b1;
      end
      S_SHIFT: begin
        ps2_dat_oe_o = dat_bit_q;
      end
      S_DONE: begin
        tx_done_o = 1'b1;
      end
      S_ERR: begin
        tx_err_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model, behavioural PS/2 device, frame/outcome scoreboard.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int STO = 200;
  localparam int PTO = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic [1:0] tx_code;
  logic       clk_oe, dat_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       bus_clk, bus_dat;

  assign bus_clk = dev_clk & ~clk_oe;
  assign bus_dat = dev_dat & ~dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYC (INH),
    .START_TO_CYC(STO),
    .PKT_TO_CYC  (PTO)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .tx_busy_o    (tx_busy),
    .tx_done_o    (tx_done),
    .tx_err_o     (tx_err),
    .tx_err_code_o(tx_code),
    .ps2_clk_i    (bus_clk),
    .ps2_dat_i    (bus_dat),
    .ps2_clk_oe_o (clk_oe),
    .ps2_dat_oe_o (dat_oe)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, acc_cnt = 0;
  int last_code = 0, err_cyc = 0, release_cyc = 0;
  int inhib_run = 0, inhib_len = 0;
  logic clk_oe_prev = 1'b0;
  logic err_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference frame: {stop=1, odd parity, data}, bit 0 goes out first
  function automatic logic [9:0] frame(input logic [7:0] d);
    int   ones;
    logic p;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    p = ((ones % 2) == 0);
    return {1'b1, p, d};
  endfunction

  // Per-cycle monitor: ready/busy coherence, released bus when idle, pulse bookkeeping
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        chk("ready_vs_busy", tx_ready, !tx_busy);
        if (tx_ready) chk("idle_bus_released", {clk_oe, dat_oe}, 2'b00);
        if (tx_done || tx_err) chk("done_err_exclusive", tx_done & tx_err, 1'b0);
        if (tx_valid && tx_ready) acc_cnt++;
        if (tx_done) done_cnt++;
        if (err_prev) chk("ready_after_err", tx_ready, 1'b1);
        if (tx_err) begin
          err_cnt++;
          last_code = int'(tx_code);
          err_cyc = cyc;
          chk("err_bus_released", {clk_oe, dat_oe}, 2'b00);
        end
        err_prev = tx_err;
        if (clk_oe_prev && !clk_oe) release_cyc = cyc;
        if (clk_oe && !dat_oe) begin
          inhib_run++;
        end else begin
          if (clk_oe && dat_oe && inhib_run > 0) inhib_len = inhib_run;
          inhib_run = 0;
        end
        clk_oe_prev = clk_oe;
      end else begin
        err_prev = 1'b0;
        clk_oe_prev = 1'b0;
        inhib_run = 0;
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit extra);
    int w;
    w = 0;
    tx_data = d;
    tx_valid = 1'b1;
    do begin
      @(negedge clk);
      w++;
    end while (!tx_ready && w < 100);
    if (w >= 100) chk("accept_timeout", 0, 1);
    step();
    tx_valid = 1'b0;
    tx_data = 8'h00;
    if (extra) begin
      repeat (150) step();
      tx_data = ~d;
      tx_valid = 1'b1;
      repeat (3) step();
      tx_valid = 1'b0;
    end
  endtask

  // Device: waits for request-to-send, clocks nedges pulses, samples host data while clock high
  task automatic device(input int half, input int nedges, input bit ack, input bit glitch,
                        output logic [9:0] bits, output int fe1_cyc);
    int w;
    w = 0;
    bits = '0;
    fe1_cyc = 0;
    while (!(bus_clk === 1'b1 && bus_dat === 1'b0) && w < 1000) begin
      step();
      w++;
    end
    if (w >= 1000) begin
      chk("device_saw_request", 0, 1);
      return;
    end
    if (glitch) begin
      repeat (10) step();
      dev_clk = 1'b0;
      repeat (2) step();
      dev_clk = 1'b1;
      repeat (20) step();
    end else begin
      repeat (half) step();
    end
    for (int k = 1; k <= nedges; k++) begin
      dev_clk = 1'b0;
      if (k == 1) fe1_cyc = cyc;
      repeat (half) step();
      dev_clk = 1'b1;
      repeat (half / 2) step();
      if (k <= 10) bits[k-1] = bus_dat;
      if (k == 10 && ack) dev_dat = 1'b0;
      repeat (half - half / 2) step();
    end
    dev_dat = 1'b1;
  endtask

  task automatic run_txn(input string name, input logic [7:0] d, input int half, input int nedges,
                         input bit ack, input bit glitch, input bit extra,
                         input int exp_done, input int exp_code,
                         output logic [9:0] bits, output int fe1);
    int d0, e0, a0, w;
    d0 = done_cnt;
    e0 = err_cnt;
    a0 = acc_cnt;
    fork
      send(d, extra);
      device(half, nedges, ack, glitch, bits, fe1);
    join
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < 5000) begin
      step();
      w++;
    end
    if (w >= 5000) chk({name, "_outcome_timeout"}, 0, 1);
    repeat (5) step();
    chk({name, "_accepts"}, acc_cnt - a0, 1);
    chk({name, "_done_pulses"}, done_cnt - d0, exp_done);
    chk({name, "_err_pulses"}, err_cnt - e0, (exp_done == 1) ? 0 : 1);
    if (exp_done == 0) chk({name, "_err_code"}, last_code, exp_code);
    if (nedges >= 10) chk({name, "_frame"}, bits, frame(d));
    chk({name, "_ready_after"}, tx_ready, 1'b1);
  endtask

  initial begin
    logic [9:0] bits;
    int         fe1;
    logic [7:0] rd;
    int         rh;

    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_err", tx_err, 1'b0);
    chk("rst_code", tx_code, 2'd0);
    chk("rst_clk_oe", clk_oe, 1'b0);
    chk("rst_dat_oe", dat_oe, 1'b0);
    rst_n = 1'b1;
    repeat (3) step();

    // 0xED with a second request while busy: one transfer only
    run_txn("ED", 8'hED, 20, 11, 1'b1, 1'b0, 1'b1, 1, 0, bits, fe1);
    chk("ED_frame_literal", bits, 10'h3ED);
    chk("ED_inhibit_len", inhib_len, INH);
    repeat (50) step();
    chk("ED_no_second_accept", tx_busy, 1'b0);

    run_txn("F4", 8'hF4, 20, 11, 1'b1, 1'b0, 1'b0, 1, 0, bits, fe1);
    chk("F4_parity_literal", bits[8], 1'b0);
    chk("F4_frame_literal", bits, 10'h2F4);
    run_txn("FF", 8'hFF, 20, 11, 1'b1, 1'b0, 1'b0, 1, 0, bits, fe1);
    chk("FF_frame_literal", bits, 10'h3FF);

    // Device never clocks
    run_txn("start_to", 8'h55, 20, 0, 1'b1, 1'b0, 1'b0, 0, 1, bits, fe1);
    chk("start_to_delay", err_cyc - release_cyc, STO);

    // No ACK
    run_txn("nack", 8'h3C, 20, 11, 1'b0, 1'b0, 1'b0, 0, 3, bits, fe1);

    // Device stalls after fifth edge
    run_txn("pkt_to", 8'h81, 20, 5, 1'b1, 1'b0, 1'b0, 0, 2, bits, fe1);
    chk("pkt_to_delay_window", (err_cyc - fe1 >= PTO) && (err_cyc - fe1 <= PTO + 10), 1'b1);

    // Error code holds across a successful transfer
    run_txn("after_err", 8'h12, 16, 11, 1'b1, 1'b0, 1'b0, 1, 0, bits, fe1);
    chk("code_holds", tx_code, 2'd2);

    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom);
      rh = int'($urandom_range(12, 25));
      run_txn("rand", rd, rh, 11, 1'b1, 1'b0, 1'b0, 1, 0, bits, fe1);
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    run_txn("glitch", 8'hED, 20, 11, 1'b1, 1'b1, 1'b0, 1, 0, bits, fe1);
    chk("glitch_frame_literal", bits, 10'h3ED);
`endif

    // Asynchronous reset while shifting
    fork
      send(8'hA5, 1'b0);
      device(20, 5, 1'b1, 1'b0, bits, fe1);
    join
    repeat (10) step();
    chk("mid_busy", tx_busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_clk_oe", clk_oe, 1'b0);
    chk("async_rst_dat_oe", dat_oe, 1'b0);
    chk("async_rst_ready", tx_ready, 1'b1);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("post_rst_idle", tx_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
